// File: rtl/pair_stim_gen_if.sv
// pair_stim_gen_if: control and stimulus bundle between the pair stimulus
// generator and the capture/DUT side.
//   start, abort, pair_ready        : capture side -> generator
//   stim[IN_SIZE]                   : operand value driven to the DUT
//   begin_pulse, end_pulse          : transition-window markers
//   pair_valid, sim_idx[SIM_W]      : completed pair and its index
//   busy, done                      : campaign status
// Modports: master = generator, slave = capture side.
interface pair_stim_gen_if #(
  parameter int unsigned IN_SIZE = 8,
  parameter int unsigned SIM_W   = 16
);

  logic               start;
  logic               abort;
  logic               pair_ready;
  logic [IN_SIZE-1:0] stim;
  logic               begin_pulse;
  logic               end_pulse;
  logic               pair_valid;
  logic [SIM_W-1:0]   sim_idx;
  logic               busy;
  logic               done;

  modport master (
    input  start,
    input  abort,
    input  pair_ready,
    output stim,
    output begin_pulse,
    output end_pulse,
    output pair_valid,
    output sim_idx,
    output busy,
    output done
  );

  modport slave (
    output start,
    output abort,
    output pair_ready,
    input  stim,
    input  begin_pulse,
    input  end_pulse,
    input  pair_valid,
    input  sim_idx,
    input  busy,
    input  done
  );

endinterface

// File: rtl/pair_stim_gen.sv
// pair_stim_gen: walks every operand pair (i, j), i outer / j inner, each in
// 0..N_VALUES-1. For each pair it drives stim=i for HOLD_CYCLES cycles, then
// stim=j for HOLD_CYCLES cycles (the transition window, marked by
// begin_pulse/end_pulse), then holds j with pair_valid=1 until pair_ready.
// A campaign ends with a one-cycle done pulse.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : synchronous active-low reset
//   bus     : pair_stim_gen_if.master (start, abort, pair_ready in;
//             stim, begin_pulse, end_pulse, pair_valid, sim_idx, busy, done out)
// Build option: define PAIR_STIM_SKIP_DIAG_EN to skip pairs with i == j.
// All outputs are registered; they are computed from the next state.
module pair_stim_gen #(
  parameter int unsigned IN_SIZE     = 8,
  parameter int unsigned N_VALUES    = 4,
  parameter int unsigned HOLD_CYCLES = 1,
  parameter int unsigned SIM_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pair_stim_gen_if.master bus
);

  // i and j must also hold N_VALUES so "past the last row" is representable
  localparam int unsigned CNT_W  = $clog2(N_VALUES + 1);
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [CNT_W-1:0]  VAL_LAST    = CNT_W'(N_VALUES - 1);
  localparam logic [CNT_W-1:0]  VAL_END     = CNT_W'(N_VALUES);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

`ifdef PAIR_STIM_SKIP_DIAG_EN
  localparam logic [CNT_W-1:0]  FIRST_J     = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0]  FIRST_J     = CNT_W'(0);
`endif

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    APPLY_I  = 3'd1,
    APPLY_J  = 3'd2,
    WAIT_ACK = 3'd3,
    FIN      = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     i_q, i_d;
  logic [CNT_W-1:0]     j_q, j_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [SIM_W-1:0]     sim_idx_q, sim_idx_d;
  logic [IN_SIZE-1:0]   stim_q, stim_d;
  logic                 begin_pulse_q, begin_pulse_d;
  logic                 end_pulse_q, end_pulse_d;
  logic                 pair_valid_q, pair_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [CNT_W-1:0]     nxt_i_c;
  logic [CNT_W-1:0]     nxt_j_c;
  logic                 last_pair_c;

  // Successor of the current pair; optionally steps over the diagonal.
  always_comb begin
    nxt_i_c = i_q;
    nxt_j_c = j_q;
    if (j_q == VAL_LAST) begin
      nxt_i_c = i_q + CNT_W'(1);
      nxt_j_c = '0;
    end else begin
      nxt_j_c = j_q + CNT_W'(1);
    end
`ifdef PAIR_STIM_SKIP_DIAG_EN
    // one extra step suffices: the pair after a diagonal is never diagonal
    if (nxt_i_c == nxt_j_c) begin
      if (nxt_j_c == VAL_LAST) begin
        nxt_i_c = nxt_i_c + CNT_W'(1);
        nxt_j_c = '0;
      end else begin
        nxt_j_c = nxt_j_c + CNT_W'(1);
      end
    end
`endif
    last_pair_c = (nxt_i_c == VAL_END);
  end

  // Next-state logic and registered-output decode.
  always_comb begin
    state_d       = state_q;
    i_d           = i_q;
    j_d           = j_q;
    hold_d        = hold_q;
    sim_idx_d     = sim_idx_q;
    stim_d        = '0;
    begin_pulse_d = 1'b0;
    end_pulse_d   = 1'b0;
    pair_valid_d  = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = APPLY_I;
          i_d       = '0;
          j_d       = FIRST_J;
          sim_idx_d = '0;
        end
      end
      APPLY_I: begin
        if (hold_q == '0) begin
          state_d = APPLY_J;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      APPLY_J: begin
        if (hold_q == '0) begin
          state_d = WAIT_ACK;
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      WAIT_ACK: begin
        if (bus.pair_ready) begin
          sim_idx_d = sim_idx_q + SIM_W'(1);
          if (last_pair_c) begin
            state_d = FIN;
          end else begin
            state_d = APPLY_I;
            i_d     = nxt_i_c;
            j_d     = nxt_j_c;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort wins over start and pair_ready in every state
    if (bus.abort) begin
      state_d   = IDLE;
      i_d       = '0;
      j_d       = '0;
      sim_idx_d = '0;
    end

    // hold counter restarts on every state change
    if (state_d != state_q) begin
      hold_d = HOLD_RELOAD;
    end

    // outputs reflect the state being entered
    unique case (state_d)
      APPLY_I: begin
        stim_d = IN_SIZE'(i_d);
        busy_d = 1'b1;
      end
      APPLY_J: begin
        stim_d        = IN_SIZE'(j_d);
        busy_d        = 1'b1;
        begin_pulse_d = (hold_d == HOLD_RELOAD);
        end_pulse_d   = (hold_d == '0);
      end
      WAIT_ACK: begin
        stim_d       = IN_SIZE'(j_d);
        busy_d       = 1'b1;
        pair_valid_d = 1'b1;
      end
      FIN: begin
        done_d = 1'b1;
      end
      default: begin
        stim_d = '0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      i_q           <= '0;
      j_q           <= '0;
      hold_q        <= HOLD_RELOAD;
      sim_idx_q     <= '0;
      stim_q        <= '0;
      begin_pulse_q <= 1'b0;
      end_pulse_q   <= 1'b0;
      pair_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      i_q           <= i_d;
      j_q           <= j_d;
      hold_q        <= hold_d;
      sim_idx_q     <= sim_idx_d;
      stim_q        <= stim_d;
      begin_pulse_q <= begin_pulse_d;
      end_pulse_q   <= end_pulse_d;
      pair_valid_q  <= pair_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign bus.stim        = stim_q;
  assign bus.begin_pulse = begin_pulse_q;
  assign bus.end_pulse   = end_pulse_q;
  assign bus.pair_valid  = pair_valid_q;
  assign bus.sim_idx     = sim_idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_pair_stim_gen.sv
// tb_pair_stim_gen: two generator instances on one clock.
//   dut_a: N_VALUES=2, HOLD_CYCLES=1 -- cycle table, start-ignore and abort
//   dut_b: N_VALUES=3, HOLD_CYCLES=3 -- reset mid-window, stalls, scoreboard
module tb_pair_stim_gen;

  localparam int HB = 3;
`ifdef PAIR_STIM_SKIP_DIAG_EN
  localparam int NP_B    = 6;
  localparam int FIRST_J = 1;
`else
  localparam int NP_B    = 9;
  localparam int FIRST_J = 0;
`endif

  logic clk;
  logic rst_n;

  pair_stim_gen_if #(.IN_SIZE(8), .SIM_W(16)) a_if ();
  pair_stim_gen_if #(.IN_SIZE(8), .SIM_W(16)) b_if ();

  pair_stim_gen #(.IN_SIZE(8), .N_VALUES(2), .HOLD_CYCLES(1), .SIM_W(16)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.master)
  );

  pair_stim_gen #(.IN_SIZE(8), .N_VALUES(3), .HOLD_CYCLES(HB), .SIM_W(16)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {stim, begin, end, valid, busy, done, sim_idx}
  function automatic logic [28:0] a_out();
    return {a_if.stim, a_if.begin_pulse, a_if.end_pulse, a_if.pair_valid,
            a_if.busy, a_if.done, a_if.sim_idx};
  endfunction

  function automatic logic [28:0] b_out();
    return {b_if.stim, b_if.begin_pulse, b_if.end_pulse, b_if.pair_valid,
            b_if.busy, b_if.done, b_if.sim_idx};
  endfunction

  typedef struct {
    logic        st;
    logic [7:0]  stim;
    logic        bp, ep, pv, bz, dn;
    logic [15:0] idx;
  } vec_t;

  function automatic vec_t mk(input logic st, input int stim, input logic bp, input logic ep,
                              input logic pv, input logic bz, input logic dn, input int idx);
    vec_t v;
    v.st = st; v.stim = 8'(stim); v.bp = bp; v.ep = ep; v.pv = pv;
    v.bz = bz; v.dn = dn; v.idx = 16'(idx);
    return v;
  endfunction

  typedef struct packed {
    logic [7:0]  i;
    logic [7:0]  j;
    logic [15:0] idx;
  } pair_t;

  pair_t sb_q[$];

  task automatic push_campaign(input int n);
    int k = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < n; j++) begin
`ifdef PAIR_STIM_SKIP_DIAG_EN
        if (i == j) continue;
`endif
        sb_q.push_back('{i: 8'(i), j: 8'(j), idx: 16'(k)});
        k++;
      end
    end
  endtask

  // Monitor for dut_b: window timing and pair contents against the scoreboard.
  int         cyc = 0;
  int         ai_cyc = 0;
  int         beg_cyc = 0;
  logic       prev_busy = 1'b0;
  logic       prev_valid = 1'b0;
  logic       prev_hs = 1'b0;
  logic [7:0] prev_stim = '0;
  logic [7:0] got_i = '0;
  pair_t      exp_p;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_busy  = 1'b0;
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (b_if.busy && (!prev_busy || prev_hs)) ai_cyc = cyc;
      if (b_if.begin_pulse) begin
        got_i   = prev_stim;
        beg_cyc = cyc;
        check("hold_i", 32'(cyc - ai_cyc), 32'(HB));
      end
      if (b_if.end_pulse) check("pulse_gap", 32'(cyc - beg_cyc), 32'(HB - 1));
      if (b_if.pair_valid && !prev_valid) check("hold_j", 32'(cyc - beg_cyc), 32'(HB));
      if (b_if.pair_valid && b_if.pair_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_p = sb_q.pop_front();
          check("pair_i", 32'(got_i), 32'(exp_p.i));
          check("pair_j", 32'(b_if.stim), 32'(exp_p.j));
          check("pair_idx", 32'(b_if.sim_idx), 32'(exp_p.idx));
        end
      end
      prev_busy  = b_if.busy;
      prev_valid = b_if.pair_valid;
      prev_hs    = b_if.pair_valid && b_if.pair_ready;
      prev_stim  = b_if.stim;
    end
  end

  vec_t tbl[$];
  int   t;
  int   budget;
  int   s;
  bit   first;
  bit   seen_done;

  initial begin
    rst_n = 1'b0;
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.pair_ready = 1'b0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.pair_ready = 1'b0;
    repeat (3) step();
    check("rst_a", 32'(a_out()), 32'd0);
    check("rst_b", 32'(b_out()), 32'd0);
    rst_n = 1'b1;
    step();

    // Cycle table for dut_a with pair_ready held high: st is applied,
    // then outputs after the next edge are compared.
`ifdef PAIR_STIM_SKIP_DIAG_EN
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1));  // start while busy: no effect
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2));  // start during FIN: no effect
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 2));
`else
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 1, 1, 1, 0, 1, 0, 1));  // start while busy: no effect
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 3));
    tbl.push_back(mk(0, 1, 1, 1, 0, 1, 0, 3));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 4));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 4));  // start during FIN: no effect
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 4));
`endif
    a_if.pair_ready = 1'b1;
    for (int k = 0; k < tbl.size(); k++) begin
      a_if.start = tbl[k].st;
      step();
      check($sformatf("vec%0d", k), 32'(a_out()),
            32'({tbl[k].stim, tbl[k].bp, tbl[k].ep, tbl[k].pv, tbl[k].bz, tbl[k].dn, tbl[k].idx}));
    end
    a_if.start = 1'b0;

    // Abort during the second pair, then restart from (0,FIRST_J).
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    t = 0;
    while (a_if.sim_idx != 16'd1 && t < 50) begin
      step();
      t++;
    end
    check("abort_reach", 32'(t < 50), 32'd1);
    a_if.abort = 1'b1;
    step();
    a_if.abort = 1'b0;
    check("abort_idle", 32'(a_out()), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("abort_nodone", 32'(a_out()), 32'd0);
    end
    a_if.start = 1'b1;
    step();
    a_if.start = 1'b0;
    check("restart_i", 32'(a_out()), 32'({8'd0, 5'b00010, 16'd0}));
    step();
    check("restart_j", 32'(a_out()), 32'({8'(FIRST_J), 5'b11010, 16'd0}));
    a_if.abort = 1'b1;
    step();
    a_if.abort = 1'b0;

    // dut_b: start pulsed while busy is ignored, then reset mid-window.
    b_if.start = 1'b1;
    step();
    b_if.start = 1'b1;
    step();
    b_if.start = 1'b0;
    t = 1;
    while (!b_if.begin_pulse && t < 50) begin
      step();
      t++;
    end
    check("start_busy_ignored", 32'(t), 32'(HB));
    rst_n = 1'b0;
    step();
    check("rst_mid_b", 32'(b_out()), 32'd0);
    rst_n = 1'b1;
    step();
    check("rst_idle_b", 32'(b_out()), 32'd0);

    // Full campaign on dut_b with stalls; first pair stalls 5 cycles.
    push_campaign(3);
    b_if.start = 1'b1;
    step();
    b_if.start = 1'b0;
    budget = 0;
    first = 1'b1;
    seen_done = 1'b0;
    while (!seen_done && budget < 2000) begin
      if (b_if.done) begin
        seen_done = 1'b1;
      end else if (b_if.pair_valid) begin
        s = first ? 5 : int'($urandom_range(0, 2));
        for (int k = 0; k < s; k++) begin
          if (first) begin
            check("stall_valid", 32'(b_if.pair_valid), 32'd1);
            check("stall_stim", 32'(b_if.stim), 32'(sb_q[0].j));
            check("stall_idx", 32'(b_if.sim_idx), 32'(sb_q[0].idx));
          end
          step();
          budget++;
        end
        first = 1'b0;
        b_if.pair_ready = 1'b1;
        step();
        budget++;
        b_if.pair_ready = 1'b0;
      end else begin
        step();
        budget++;
      end
    end
    check("campaign_done", 32'(seen_done), 32'd1);
    check("final_idx", 32'(b_if.sim_idx), 32'(NP_B));
    check("fin_busy", 32'(b_if.busy), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    step();
    check("done_one_cycle", 32'(b_if.done), 32'd0);
    check("idle_after_fin", 32'({b_if.busy, b_if.stim}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
